// File: rtl/elastic_pipe_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elastic_pipe_chain_pkg
//  Brief    : Shared sizing and saturating-arithmetic helpers for the chain.
//  Revision : 1.0 - initial release
// ============================================================================
package elastic_pipe_chain_pkg;

    // Occupancy spans 0 .. 2*STAGES inclusive.
    function automatic int occWidth(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

    // Saturating add clamped to the largest value representable in width bits.
    function automatic logic [63:0] satAdd(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int          width);
        logic [64:0] sum;
        logic [63:0] maxVal;
        maxVal = (64'd1 << width) - 64'd1;
        sum    = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, maxVal}) begin
            return maxVal;
        end
        return sum[63:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/elastic_pipe_chain_if.sv
`default_nettype none
// ============================================================================
//  Module   : elastic_pipe_chain_if
//  Brief    : Valid/ready payload stream used on both sides of the chain.
//  Revision : 1.0 - initial release
// ============================================================================
interface elastic_pipe_chain_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/elastic_pipe_chain_stage.sv
`default_nettype none
// ============================================================================
//  Module   : elastic_skid_stage
//  Brief    : One main+skid register stage with registered upstream ready.
//  Revision : 1.0 - initial release
// ============================================================================
module elastic_skid_stage
    import elastic_pipe_chain_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_flush,
    input  wire logic              i_valid,
    input  wire logic [DATA_W-1:0] i_data,
    output      logic              o_ready,
    output      logic              o_valid,
    output      logic [DATA_W-1:0] o_data,
    input  wire logic              i_ready,
    output      logic [1:0]        o_count
);

    logic              r_mainValid;
    logic [DATA_W-1:0] r_mainData;
    logic              r_skidValid;
    logic [DATA_W-1:0] r_skidData;

    logic w_accept;
    logic w_mainFree;

    assign w_accept   = i_valid & ~r_skidValid;
    assign w_mainFree = ~r_mainValid | i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainValid <= 1'b0;
            r_mainData  <= '0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
        end else if (i_flush) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (w_mainFree) begin
            // A held skid word always precedes new input to keep FIFO order;
            // while skid is full o_ready is low, so no input competes here.
            if (r_skidValid) begin
                r_mainData  <= r_skidData;
                r_mainValid <= 1'b1;
                r_skidValid <= 1'b0;
            end else begin
                r_mainValid <= w_accept;
                if (w_accept) begin
                    r_mainData <= i_data;
                end
            end
        end else if (w_accept) begin
            r_skidData  <= i_data;
            r_skidValid <= 1'b1;
        end
    end

    assign o_ready = ~r_skidValid;
    assign o_valid = r_mainValid;
    assign o_data  = r_mainData;
    assign o_count = {1'b0, r_mainValid} + {1'b0, r_skidValid};

endmodule
`default_nettype wire

// File: rtl/elastic_pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module   : elastic_pipe_chain
//  Brief    : STAGES-deep elastic pipeline with flush, occupancy and drop count.
//  Revision : 1.0 - initial release
// ============================================================================
module elastic_pipe_chain
    import elastic_pipe_chain_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    elastic_pipe_chain_if.slave             in_if,
    elastic_pipe_chain_if.master            out_if,
    input  wire logic                       flush,
    output      logic [occWidth(STAGES)-1:0] occupancy,
    output      logic [CNT_W-1:0]           flush_drops
);

    localparam int c_OCC_W = occWidth(STAGES);

    logic              w_valid [0:STAGES];
    logic [DATA_W-1:0] w_data  [0:STAGES];
    logic              w_ready [0:STAGES];
    logic [1:0]        w_cnt   [0:STAGES-1];

    logic               r_live;
    logic [CNT_W-1:0]   r_flushDrops;
    logic [c_OCC_W-1:0] w_occSum;
    logic [c_OCC_W-1:0] w_discard;
    logic               w_deliver;

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign w_valid[0]      = in_if.valid & r_live;
    assign w_data[0]       = in_if.data;
    assign w_ready[STAGES] = out_if.ready;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            elastic_skid_stage #(
                .DATA_W (DATA_W)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_flush (flush),
                .i_valid (w_valid[gi]),
                .i_data  (w_data[gi]),
                .o_ready (w_ready[gi]),
                .o_valid (w_valid[gi+1]),
                .o_data  (w_data[gi+1]),
                .i_ready (w_ready[gi+1]),
                .o_count (w_cnt[gi])
            );
        end
    endgenerate

    always_comb begin
        w_occSum = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_occSum = w_occSum + c_OCC_W'(w_cnt[k]);
        end
    end

    assign w_deliver = w_valid[STAGES] & out_if.ready;
    // The word leaving at the flush edge is delivered, not discarded.
    assign w_discard = w_occSum - c_OCC_W'(w_deliver);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flushDrops <= '0;
        end else if (flush) begin
            r_flushDrops <= CNT_W'(satAdd(64'(r_flushDrops), 64'(w_discard), CNT_W));
        end
    end

    assign in_if.ready  = r_live & w_ready[0];
    assign out_if.valid = w_valid[STAGES];
    assign out_if.data  = w_data[STAGES];
    assign occupancy    = w_occSum;
    assign flush_drops  = r_flushDrops;

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elastic_pipe_chain
//  Brief    : Directed self-checking bench for elastic_pipe_chain.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_elastic_pipe_chain;

    logic       clk;
    logic       rst_n;
    logic       flushA;
    logic       flushB;
    logic [2:0] occA;
    logic [2:0] occB;
    logic [15:0] dropsA;
    logic [1:0]  dropsB;

    int checks;
    int errors;

    elastic_pipe_chain_if #(.DATA_W(32)) inA  ();
    elastic_pipe_chain_if #(.DATA_W(32)) outA ();
    elastic_pipe_chain_if #(.DATA_W(32)) inB  ();
    elastic_pipe_chain_if #(.DATA_W(32)) outB ();

    elastic_pipe_chain #(.DATA_W(32), .STAGES(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (inA),
        .out_if      (outA),
        .flush       (flushA),
        .occupancy   (occA),
        .flush_drops (dropsA)
    );

    elastic_pipe_chain #(.DATA_W(32), .STAGES(2), .CNT_W(2)) dutSat (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (inB),
        .out_if      (outB),
        .flush       (flushB),
        .occupancy   (occB),
        .flush_drops (dropsB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected self-termination");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  sent, rcv, cyc, firstAcc, firstOut, n, k;
    bit  accNow;
    logic [31:0] nxt;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        flushA = 1'b0;
        flushB = 1'b0;
        inA.valid = 1'b0; inA.data = '0; outA.ready = 1'b0;
        inB.valid = 1'b0; inB.data = '0; outB.ready = 1'b0;

        // Reset state
        #2;
        checkVal("rst_out_valid", outA.valid, 0);
        checkVal("rst_out_data",  outA.data, 0);
        checkVal("rst_occ",       occA, 0);
        checkVal("rst_drops",     dropsA, 0);
        checkVal("rst_in_ready",  inA.ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checkVal("rel_in_ready",  inA.ready, 1);
        checkVal("rel_out_valid", outA.valid, 0);
        checkVal("rel_occ",       occA, 0);
        checkVal("rel_drops",     dropsA, 0);

        // Streaming with out_ready held high
        outA.ready = 1'b1; inA.valid = 1'b1; inA.data = 32'd1;
        sent = 0; rcv = 0; cyc = 0; firstAcc = -1; firstOut = -1;
        while (rcv < 16 && cyc < 60) begin
            accNow = inA.valid && inA.ready;
            if (accNow && firstAcc < 0) firstAcc = cyc;
            if (outA.valid) begin
                if (firstOut < 0) firstOut = cyc;
                checkVal("stream_data", outA.data, 64'(rcv + 1));
                rcv++;
            end else if (firstOut >= 0) begin
                checkVal("stream_gap", outA.valid, 1);
            end
            if (cyc >= 2 && cyc <= 16) checkVal("stream_occ", occA, 2);
            tick();
            if (accNow) begin
                sent++;
                inA.data = 32'(sent + 1);
                if (sent == 16) inA.valid = 1'b0;
            end
            cyc++;
        end
        checkVal("stream_count",   64'(rcv), 16);
        checkVal("stream_latency", 64'(firstOut - firstAcc), 2);
        checkVal("stream_empty",   occA, 0);

        // Backpressure: capacity is four words
        outA.ready = 1'b0; nxt = 32'hA; n = 0;
        inA.valid = 1'b1; inA.data = nxt;
        repeat (8) begin
            accNow = inA.ready;
            tick();
            if (accNow) begin
                n++;
                nxt = nxt + 32'd1;
                inA.data = nxt;
            end
        end
        inA.valid = 1'b0;
        checkVal("bp_accepts",  64'(n), 4);
        checkVal("bp_in_ready", inA.ready, 0);
        checkVal("bp_occ",      occA, 4);
        checkVal("bp_head",     outA.data, 32'hA);
        outA.ready = 1'b1; rcv = 0; k = 0;
        while (rcv < 4 && k < 12) begin
            if (outA.valid) begin
                checkVal("bp_drain_data", outA.data, 64'(32'hA + rcv));
                rcv++;
            end
            tick();
            k++;
        end
        checkVal("bp_drain_count", 64'(rcv), 4);
        checkVal("bp_no_dup",      outA.valid, 0);
        checkVal("bp_drain_occ",   occA, 0);

        // Flush with three held entries
        outA.ready = 1'b0; inA.valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inA.data = 32'h11 + 32'(i);
            tick();
        end
        checkVal("fl_pre_occ",  occA, 3);
        checkVal("fl_head",     outA.data, 32'h11);
        outA.ready = 1'b1; flushA = 1'b1; inA.data = 32'hEE;
        checkVal("fl_head_valid", outA.valid, 1);
        checkVal("fl_in_ready",   inA.ready, 1);
        tick();
        flushA = 1'b0; inA.valid = 1'b0;
        checkVal("fl_occ",       occA, 0);
        checkVal("fl_out_valid", outA.valid, 0);
        checkVal("fl_in_ready_after", inA.ready, 1);
        checkVal("fl_drops",     dropsA, 2);
        repeat (3) tick();
        checkVal("fl_ee_dropped", outA.valid, 0);

        // Flush of an empty chain leaves the counter alone
        flushA = 1'b1;
        tick();
        flushA = 1'b0;
        checkVal("fl_empty_drops", dropsA, 2);

        // Saturating drop counter with CNT_W=2
        for (int f = 0; f < 3; f++) begin
            inB.valid = 1'b1; n = 0; k = 0;
            while (n < 4 && k < 10) begin
                accNow = inB.ready;
                inB.data = 32'h100 + 32'(n);
                tick();
                if (accNow) n++;
                k++;
            end
            inB.valid = 1'b0;
            checkVal("sat_pre_occ", occB, 4);
            flushB = 1'b1;
            tick();
            flushB = 1'b0;
            checkVal("sat_drops", dropsB, 3);
            checkVal("sat_occ",   occB, 0);
        end

        // Asynchronous reset between edges
        outA.ready = 1'b0; inA.valid = 1'b1; inA.data = 32'h55;
        tick();
        inA.data = 32'h56;
        tick();
        inA.valid = 1'b0;
        checkVal("ar_pre_valid", outA.valid, 1);
        #3 rst_n = 1'b0;
        #1;
        checkVal("ar_out_valid", outA.valid, 0);
        checkVal("ar_out_data",  outA.data, 0);
        checkVal("ar_in_ready",  inA.ready, 0);
        checkVal("ar_occ",       occA, 0);
        checkVal("ar_drops",     dropsA, 0);
        checkVal("ar_sat_drops", dropsB, 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkVal("ar_rel_in_ready", inA.ready, 1);
        checkVal("ar_rel_drops",    dropsA, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
